// File: rtl/pwm_fade_scheduler.sv
// pwm_fade_scheduler
// Holds a target duty per LED channel (written over the SPI register bus) and
// walks each channel's live duty toward its target by a programmable step,
// once per programmable tick, so host writes become smooth fades.
// Optional build macro: GAMMA_CORRECT_EN -- maps each output byte through
// ((live+1)*live)>>8 for a perceptually linear fade (one extra output cycle).
module pwm_fade_scheduler #(
  parameter int          NUM_CH   = 7,
  parameter int          PRESCALE = 256,
  parameter logic [7:0]  RATE_RST = 8'd3,
  parameter logic [7:0]  STEP_RST = 8'd1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            address,
  input  logic [7:0]            data,
  input  logic                  data_ready,
  output logic [NUM_CH*8-1:0]   duty_flat,
  output logic                  busy,
  output logic                  settled
);

  localparam int CNT_W = $clog2(256 * PRESCALE);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {
    IDLE,
    SWEEP
  } state_e;

  logic [7:0]           r_target [NUM_CH];
  logic [7:0]           r_live   [NUM_CH];
  logic [7:0]           r_rate;
  logic [7:0]           r_activeRate;
  logic [7:0]           r_step;
  logic [CNT_W-1:0]     r_prescale;
  state_e               r_state;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_busy;
  logic                 r_settled;
  logic [NUM_CH*8-1:0]  r_duty;

  logic [31:0]          w_periodLast;
  logic                 w_tick;
  logic                 w_clearAll;
  logic                 w_targetWr;
  logic [IDX_W-1:0]     w_wrIdx;
  logic [7:0]           w_rateNext;
  logic [7:0]           w_curLive;
  logic [7:0]           w_curTarget;
  logic [8:0]           w_up;
  logic [8:0]           w_down;
  logic [7:0]           w_nextLive;
  logic                 w_allMatch;
  logic [7:0]           w_dutySrc [NUM_CH];

  // The period latched at the last wrap sets when the prescaler fires, so a
  // rate write mid-period only changes the period that starts at the next wrap.
  assign w_periodLast = (32'(r_activeRate) + 32'd1) * 32'(PRESCALE) - 32'd1;
  assign w_tick       = (32'(r_prescale) == w_periodLast);

  assign w_clearAll   = data_ready && (address == 8'hFF);
  assign w_targetWr   = data_ready && (address >= 8'd1) && (address <= 8'(NUM_CH));
  assign w_wrIdx      = IDX_W'(address - 8'd1);
  assign w_rateNext   = (data_ready && (address == 8'h10)) ? data : r_rate;

  assign w_curLive    = r_live[r_idx];
  assign w_curTarget  = r_target[r_idx];

  // Next live value for the channel in its sweep slot: step toward target in
  // 9-bit arithmetic and clamp at the target so it never overshoots or wraps.
  always_comb begin
    w_up       = {1'b0, w_curLive} + {1'b0, r_step};
    w_down     = {1'b0, w_curLive} - {1'b0, r_step};
    w_nextLive = w_curLive;
    if (r_step == 8'd0) begin
      w_nextLive = w_curTarget;
    end else if (w_curLive < w_curTarget) begin
      w_nextLive = (w_up >= {1'b0, w_curTarget}) ? w_curTarget : w_up[7:0];
    end else if (w_curLive > w_curTarget) begin
      w_nextLive = (w_down[8] || (w_down[7:0] <= w_curTarget)) ? w_curTarget : w_down[7:0];
    end
  end

  // Settled means every live duty has reached its target.
  always_comb begin
    w_allMatch = 1'b1;
    for (int k = 0; k < NUM_CH; k++) begin
      if (r_live[k] != r_target[k]) begin
        w_allMatch = 1'b0;
      end
    end
  end

  // Register file, prescaler and sweep FSM; the clear-all write wins over everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_target[k] <= 8'd0;
        r_live[k]   <= 8'd0;
      end
      r_rate       <= RATE_RST;
      r_activeRate <= RATE_RST;
      r_step       <= STEP_RST;
      r_prescale   <= '0;
      r_state      <= IDLE;
      r_idx        <= '0;
      r_busy       <= 1'b0;
    end else if (w_clearAll) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_target[k] <= 8'd0;
        r_live[k]   <= 8'd0;
      end
      r_prescale <= '0;
      r_state    <= IDLE;
      r_idx      <= '0;
      r_busy     <= 1'b0;
    end else begin
      if (w_tick) begin
        r_prescale   <= '0;
        r_activeRate <= w_rateNext;
      end else begin
        r_prescale <= r_prescale + 1'b1;
      end

      if (data_ready && (address == 8'h10)) begin
        r_rate <= data;
      end
      if (data_ready && (address == 8'h11)) begin
        r_step <= data;
      end
      if (w_targetWr) begin
        r_target[w_wrIdx] <= data;
      end

      case (r_state)
        IDLE: begin
          if (w_tick) begin
            r_state <= SWEEP;
            r_idx   <= '0;
            r_busy  <= 1'b1;
          end
        end
        SWEEP: begin
          r_live[r_idx] <= w_nextLive;
          if (r_idx == IDX_W'(NUM_CH - 1)) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_idx   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef GAMMA_CORRECT_EN
  logic [15:0] w_gammaProd [NUM_CH];
  logic [7:0]  r_gamma     [NUM_CH];

  // Square-law product per channel; (255+1)*255 still fits in 16 bits.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      w_gammaProd[k] = (16'(r_live[k]) + 16'd1) * 16'(r_live[k]);
    end
  end

  // Gamma stage registers the mapped byte, adding one cycle before the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_gamma[k] <= 8'd0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_gamma[k] <= 8'(w_gammaProd[k] >> 8);
      end
    end
  end

  // Output bytes come from the gamma stage.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      w_dutySrc[k] = r_gamma[k];
    end
  end
`else
  // Output bytes carry the live duties unchanged.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      w_dutySrc[k] = r_live[k];
    end
  end
`endif

  // Registered outputs: packed duty bus and settled flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty    <= '0;
      r_settled <= 1'b1;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_duty[8*k +: 8] <= w_dutySrc[k];
      end
      r_settled <= w_allMatch;
    end
  end

  assign duty_flat = r_duty;
  assign busy      = r_busy;
  assign settled   = r_settled;

endmodule

// File: tb/tb_pwm_fade_scheduler.sv
// tb_pwm_fade_scheduler
// Directed bench for pwm_fade_scheduler with PRESCALE = 4. Edge numbers count
// rising clock edges since the last reset release; a write "at edge N" is
// captured by the DUT on edge N. Outputs are sampled 1 time unit after an edge.
// Honours GAMMA_CORRECT_EN for expected output bytes and output latency.
module tb_pwm_fade_scheduler;

  localparam int NUM_CH   = 7;
  localparam int PRESCALE = 4;
`ifdef GAMMA_CORRECT_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [7:0]           address = 8'd0;
  logic [7:0]           data = 8'd0;
  logic                 data_ready = 1'b0;
  logic [NUM_CH*8-1:0]  duty_flat;
  logic                 busy;
  logic                 settled;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  pwm_fade_scheduler #(
    .NUM_CH   (NUM_CH),
    .PRESCALE (PRESCALE),
    .RATE_RST (8'd3),
    .STEP_RST (8'd1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .address    (address),
    .data       (data),
    .data_ready (data_ready),
    .duty_flat  (duty_flat),
    .busy       (busy),
    .settled    (settled)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Edge counter since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #50000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] gam(input logic [7:0] v);
`ifdef GAMMA_CORRECT_EN
    logic [15:0] p;
    p = (16'(v) + 16'd1) * 16'(v);
    return p[15:8];
`else
    return v;
`endif
  endfunction

  task automatic waitUntil(input int e);
    int guard;
    guard = 0;
    while (cyc < e && guard < 1000) begin
      @(posedge clk);
      #1;
      guard++;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] dat, input int atEdge);
    waitUntil(atEdge - 1);
    address    = addr;
    data       = dat;
    data_ready = 1'b1;
    waitUntil(atEdge);
    data_ready = 1'b0;
    address    = 8'd0;
    data       = 8'd0;
  endtask

  task automatic checkByte(input string tag, input int ch, input logic [7:0] raw, input int atEdge);
    waitUntil(atEdge + LAT);
    checkOutput(tag, 64'(duty_flat[8*ch +: 8]), 64'(gam(raw)));
  endtask

  task automatic checkBusy(input string tag, input int atEdge, input logic exp);
    waitUntil(atEdge);
    checkOutput(tag, 64'(busy), 64'(exp));
  endtask

  task automatic checkSettled(input string tag, input int atEdge, input logic exp);
    waitUntil(atEdge);
    checkOutput(tag, 64'(settled), 64'(exp));
  endtask

  initial begin
    // Power-on reset values.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_duty", 64'(duty_flat), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_settled", 64'(settled), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Fade ch0 to 0x40 in steps of 0x10; rate 1 gives an 8-cycle period.
    applyStimulus(8'h10, 8'h01, 2);
    applyStimulus(8'h11, 8'h10, 3);
    applyStimulus(8'h01, 8'h40, 4);
    checkSettled("settled_after_wr", 6, 1'b0);
    checkBusy("first_tick_pre", 15, 1'b0);
    checkBusy("first_tick", 16, 1'b1);
    checkByte("ch0_latency", 0, 8'h00, 17);
    checkByte("ch0_step1", 0, 8'h10, 18);
    checkBusy("sweep_end", 23, 1'b0);
    checkBusy("tick_rate1", 24, 1'b1);
    checkByte("ch0_step2", 0, 8'h20, 26);
    checkByte("ch0_step3", 0, 8'h30, 34);
    checkSettled("settled_pre", 41, 1'b0);
    checkSettled("settled_post", 42, 1'b1);
    checkByte("ch0_step4", 0, 8'h40, 42);

    // ch2 to 0x50 by jump, then 0x60 with step 0x30 (clamped), then down to 0.
    applyStimulus(8'h11, 8'h00, 44);
    applyStimulus(8'h03, 8'h50, 45);
    checkByte("ch2_jump", 2, 8'h50, 52);
    applyStimulus(8'h11, 8'h30, 54);
    applyStimulus(8'h03, 8'h60, 55);
    checkByte("ch2_clamp_up", 2, 8'h60, 60);
    applyStimulus(8'h03, 8'h00, 62);
    checkByte("ch2_down1", 2, 8'h30, 68);
    checkByte("ch2_down2", 2, 8'h00, 76);

    // Step 0: ch6 jumps to full scale in one sweep.
    applyStimulus(8'h11, 8'h00, 78);
    applyStimulus(8'h07, 8'hFF, 79);
    checkByte("ch6_full", 6, 8'hFF, 88);

    // Target write in the same cycle ch2 is processed (tick 88, ch2 at 91).
    applyStimulus(8'h03, 8'h22, 91);
    checkByte("ch2_same_cycle_old", 2, 8'h00, 92);
    // Tick 96: ch3 not yet processed at 98, ch0 already processed at 99.
    applyStimulus(8'h04, 8'h33, 98);
    applyStimulus(8'h01, 8'h11, 99);
    checkByte("ch2_same_cycle_new", 2, 8'h22, 100);
    checkByte("ch3_pending_wr", 3, 8'h33, 101);
    checkByte("ch0_done_wr_keep", 0, 8'h40, 101);
    checkByte("ch0_next_sweep", 0, 8'h11, 106);

    // Ignored addresses must not disturb targets or the tick period.
    applyStimulus(8'h00, 8'h99, 108);
    applyStimulus(8'h20, 8'h99, 109);
    checkBusy("ignored_idle", 119, 1'b0);
    checkBusy("ignored_tick", 120, 1'b1);
    checkSettled("ignored_settled", 121, 1'b1);
    waitUntil(121 + LAT);
    checkOutput("ignored_duty", 64'(duty_flat),
                64'({gam(8'hFF), gam(8'h00), gam(8'h00), gam(8'h33), gam(8'h22), gam(8'h00), gam(8'h11)}));

    // Clear-all mid-sweep (tick 128).
    checkBusy("abort_pre", 130, 1'b1);
    applyStimulus(8'hFF, 8'h00, 131);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkSettled("abort_settled", 132, 1'b1);
    waitUntil(132 + LAT);
    checkOutput("abort_duty", 64'(duty_flat), 64'd0);
    applyStimulus(8'h01, 8'h77, 135);
    checkBusy("abort_presc_pre", 138, 1'b0);
    checkBusy("abort_presc_tick", 139, 1'b1);
    checkByte("ch0_after_abort", 0, 8'h77, 141);

    // Asynchronous reset in the middle of a sweep.
    checkBusy("mid_sweep", 143, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_duty", 64'(duty_flat), 64'd0);
    checkOutput("arst_busy", 64'(busy), 64'd0);
    checkOutput("arst_settled", 64'(settled), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset rate (period 16) and reset step (1) are back in force.
    applyStimulus(8'h01, 8'h05, 2);
    checkBusy("rst_rate_pre", 15, 1'b0);
    checkBusy("rst_rate_tick", 16, 1'b1);
    checkByte("rst_step", 0, 8'h01, 18);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
